// File: rtl/mci_dmi_pkg.sv
// Shared MCI uncore DMI definitions: register addresses and MCU SRAM sequencer state encoding.
package mci_dmi_pkg;

  localparam logic [6:0] MCI_DMI_MCU_SRAM_ADDR = 7'h58;
  localparam logic [6:0] MCI_DMI_MCU_SRAM_DATA = 7'h59;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdReq  = 2'd1,
    StRdWait = 2'd2,
    StWrReq  = 2'd3
  } mci_dmi_sram_seq_state_e;

endpackage

// File: rtl/mci_dmi_mcu_sram_seq.sv
// Debug access to MCU SRAM through the indirect ADDR/DATA uncore DMI registers, with an
// auto-incrementing pointer and a one-word read prefetch buffer.
module mci_dmi_mcu_sram_seq
  import mci_dmi_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_b,
  input  logic                   i_dmi_access_en,
  input  logic                   i_dmi_reg_en,
  input  logic                   i_dmi_reg_wr_en,
  input  logic [6:0]             i_dmi_reg_addr,
  input  logic [DATA_W-1:0]      i_dmi_reg_wdata,
  output logic [DATA_W-1:0]      o_dmi_reg_rdata,
  output logic                   o_dmi_reg_hit,
  output logic                   o_sram_req,
  output logic                   o_sram_we,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0]      o_sram_wdata,
  input  logic                   i_sram_gnt,
  input  logic                   i_sram_rvalid,
  input  logic [DATA_W-1:0]      i_sram_rdata,
  output logic                   o_busy,
  output logic                   o_err
);

  mci_dmi_sram_seq_state_e r_state, w_state_d;
  logic [SRAM_ADDR_W-1:0]  r_ptr, w_ptr_d;
  logic [DATA_W-1:0]       r_pf_data, w_pf_data_d;
  logic                    r_pf_valid, w_pf_valid_d;
  logic [DATA_W-1:0]       r_wbuf, w_wbuf_d;
  logic                    r_err, w_err_d;
  // Set when debug access is revoked mid-transaction; the in-flight result must not be kept.
  logic                    r_abort, w_abort_d;

  logic w_sel_addr, w_sel_data, w_acc, w_idle;
  logic w_addr_wr, w_data_wr, w_data_rd, w_illegal;

  assign w_sel_addr = (i_dmi_reg_addr == MCI_DMI_MCU_SRAM_ADDR);
  assign w_sel_data = (i_dmi_reg_addr == MCI_DMI_MCU_SRAM_DATA);
  assign w_acc      = i_dmi_reg_en && i_dmi_access_en;
  assign w_idle     = (r_state == StIdle);
  assign w_addr_wr  = w_acc && i_dmi_reg_wr_en && w_sel_addr;
  assign w_data_wr  = w_acc && i_dmi_reg_wr_en && w_sel_data;
  assign w_data_rd  = w_acc && !i_dmi_reg_wr_en && w_sel_data;
  assign w_illegal  = ((w_addr_wr || w_data_wr || w_data_rd) && !w_idle) ||
                      (w_data_rd && !r_pf_valid);

  assign o_dmi_reg_hit = i_dmi_reg_en && (w_sel_addr || w_sel_data);

  always_comb begin
    o_dmi_reg_rdata = '0;
    if (i_dmi_access_en) begin
      if (w_sel_addr) begin
        o_dmi_reg_rdata = DATA_W'(r_ptr);
      end else if (w_sel_data && w_idle && r_pf_valid) begin
        o_dmi_reg_rdata = r_pf_data;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_pf_data_d  = r_pf_data;
    w_pf_valid_d = r_pf_valid;
    w_wbuf_d     = r_wbuf;
    w_err_d      = r_err;
    w_abort_d    = r_abort;

    if (!i_dmi_access_en) begin
      w_pf_valid_d = 1'b0;
      if (!w_idle) w_abort_d = 1'b1;
    end
    if (w_illegal) w_err_d = 1'b1;

    unique case (r_state)
      StIdle: begin
        w_abort_d = 1'b0;
        if (!w_illegal) begin
          if (w_addr_wr) begin
            w_ptr_d      = i_dmi_reg_wdata[SRAM_ADDR_W-1:0];
            w_pf_valid_d = 1'b0;
            w_err_d      = 1'b0;
            w_state_d    = StRdReq;
          end else if (w_data_rd) begin
            w_ptr_d      = r_ptr + SRAM_ADDR_W'(1);
            w_pf_valid_d = 1'b0;
            w_state_d    = StRdReq;
          end else if (w_data_wr) begin
            w_wbuf_d     = i_dmi_reg_wdata;
            w_pf_valid_d = 1'b0;
            w_state_d    = StWrReq;
          end
        end
      end
      StRdReq: begin
        if (i_sram_gnt) w_state_d = StRdWait;
      end
      StRdWait: begin
        if (i_sram_rvalid) begin
          if (i_dmi_access_en && !r_abort) begin
            w_pf_data_d  = i_sram_rdata;
            w_pf_valid_d = 1'b1;
          end
          w_state_d = StIdle;
        end
      end
      StWrReq: begin
        if (i_sram_gnt) begin
          w_ptr_d   = r_ptr + SRAM_ADDR_W'(1);
          w_state_d = (i_dmi_access_en && !r_abort) ? StRdReq : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_pf_data  <= '0;
      r_pf_valid <= 1'b0;
      r_wbuf     <= '0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_pf_data  <= w_pf_data_d;
      r_pf_valid <= w_pf_valid_d;
      r_wbuf     <= w_wbuf_d;
      r_err      <= w_err_d;
      r_abort    <= w_abort_d;
    end
  end

  // All SRAM-side outputs decode registers only, so they hold steady across a stalled request.
  assign o_sram_req   = (r_state == StRdReq) || (r_state == StWrReq);
  assign o_sram_we    = (r_state == StWrReq);
  assign o_sram_addr  = r_ptr;
  assign o_sram_wdata = r_wbuf;
  assign o_busy       = !w_idle;
  assign o_err        = r_err;

endmodule

// File: doc/mci_dmi_mcu_sram_seq.md
# mci_dmi_mcu_sram_seq

Sequencer for debug (DMI) access to MCU SRAM through the indirect MCU_SRAM_ADDR (0x58) / MCU_SRAM_DATA (0x59) uncore DMI registers. It owns the address pointer and a one-word prefetch buffer, and issues SRAM read and write transactions over a req/gnt/rvalid port. That port is arbitrated in MCI against MCU traffic. Reads of DATA return the prefetched word with zero added latency, and every DATA access auto-increments the pointer. The block sits between the MCI uncore DMI decode and the MCU SRAM arbiter.

## Interface
- SRAM_ADDR_W, 16, dword address width of MCU SRAM
- DATA_W, 32, data width; DMI and SRAM widths are equal
- clk  in  1  MCI clock
- rst_b  in  1  asynchronous, active-low reset
- dmi_access_en  in  1  debug unlock; when 0, the block ignores all DMI writes and returns rdata 0
- dmi_reg_en  in  1  uncore DMI access strobe, one cycle per access
- dmi_reg_wr_en  in  1  1 = write, 0 = read; qualified by dmi_reg_en
- dmi_reg_addr  in  7  uncore DMI register address
- dmi_reg_wdata  in  DATA_W  write data
- dmi_reg_rdata  out  DATA_W  read data for 0x58/0x59, 0 otherwise
- dmi_reg_hit  out  1  dmi_reg_en and addr is 0x58 or 0x59
- sram_req  out  1  transaction request, held until sram_gnt
- sram_we  out  1  1 = write
- sram_addr  out  SRAM_ADDR_W  dword address
- sram_wdata  out  DATA_W  write data
- sram_gnt  in  1  request accepted this cycle
- sram_rvalid  in  1  read data valid; arrives ≥1 cycle after gnt
- sram_rdata  in  DATA_W  read data
- busy  out  1  FSM not IDLE
- err  out  1  sticky protocol error; cleared by a DMI write to 0x58

## Operation
- Registers: ptr[SRAM_ADDR_W-1:0], pf_data[DATA_W-1:0], pf_valid, wbuf[DATA_W-1:0], err.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE: sram_req=0.
  - RD_REQ: req=1, we=0, addr=ptr; goes to RD_WAIT on gnt.
  - RD_WAIT: on rvalid, pf_data←rdata, pf_valid←1, then IDLE.
  - WR_REQ: req=1, we=1, addr=ptr, wdata=wbuf; on gnt, ptr←ptr+1 and go to RD_REQ to prefetch the next word.
- Write to 0x58 (from IDLE): ptr←wdata[SRAM_ADDR_W-1:0], pf_valid←0, err←0, then RD_REQ.
- Read of 0x58: rdata = zero-extended ptr; no side effect.
- Read of 0x59 with pf_valid=1 (from IDLE): rdata=pf_data; ptr←ptr+1, pf_valid←0, then RD_REQ.
- Write to 0x59 (from IDLE): wbuf←wdata, pf_valid←0, then WR_REQ.
- Any 0x58 write or 0x59 access while busy=1, or a 0x59 read with pf_valid=0: err←1 and the access is dropped, with no state change. A dropped read returns 0. Reads of 0x58 are always legal.
- ptr increments modulo 2^SRAM_ADDR_W, so max+1 wraps to 0.
- dmi_access_en falling with the FSM not IDLE: the outstanding SRAM transaction completes and the FSM returns to IDLE. The returned data is discarded and pf_valid←0. While dmi_access_en=0, no new transactions start.
- Reset values: all outputs 0, FSM IDLE, ptr 0, pf_valid 0, err 0.

## Timing
- dmi_reg_rdata and dmi_reg_hit are combinational from registered state and dmi_reg_addr. They are valid in the same cycle as dmi_reg_en.
- The DMI-side state update takes effect on the clock edge that ends the dmi_reg_en cycle. sram_req rises the following cycle.
- sram_req, sram_we, sram_addr and sram_wdata are registered and stay stable from request until gnt. sram_req falls in the cycle after gnt.
- Minimum prefetch latency from the 0x58 write strobe to pf_valid=1 is 3 cycles, with gnt in the same cycle as req and rvalid one cycle later. Extra arbiter stall cycles add directly.
- gnt and rvalid are ignored in IDLE. An rvalid that arrives in RD_REQ is a protocol violation and is ignored.
- Asserting rst_b low mid-transaction forces IDLE immediately and drops sram_req asynchronously.

## Structure
- Add MCI_DMI_MCU_SRAM_ADDR and MCI_DMI_MCU_SRAM_DATA to mci_dmi_pkg, reusing the existing 0x58/0x59 constants.
- Add the FSM state enum mci_dmi_sram_seq_state_e (2 bits) to mci_dmi_pkg.
- Single module; no sub-module.

## Test plan
- Reset, then read 0x58 and 0x59 → 0 and 0; read 0x59 with pf_valid=0 → err=1. Write 0x58 → err clears.
- Write 0x58=0x0010 with SRAM[0x10]=0xA5A5_0001 and SRAM[0x11]=0xA5A5_0002 → one read at addr 0x10. Then read 0x59 twice, waiting for idle between reads → 0xA5A5_0001 then 0xA5A5_0002, with ptr=0x12 and a prefetch read issued at 0x12.
- Write 0x58=0x0020, then write 0x59=0xDEAD_BEEF and 0xCAFE_F00D with idle between → SRAM writes at 0x20 and 0x21, prefetch reads at 0x21 and 0x22, and final ptr=0x22.
- Hold gnt low for 10 cycles during a prefetch → sram_req and address stay stable, busy=1. A 0x59 write during the stall → err=1 and no SRAM write.
- ptr=0xFFFF and read 0x59 → ptr wraps to 0x0000 and a prefetch read is issued at 0x0000.
- Drop dmi_access_en while in RD_WAIT → the read completes, then pf_valid=0 and rdata=0. Assert rst_b low while in WR_REQ → sram_req=0 immediately and all state returns to its reset values.
